// File: rtl/dk3_audio_out.sv
// Audio post-stage: timed mute after reset, linear fade-in and fade-out, and 2-bit master attenuation.
// Left and right carry the same signal. Output is one registered cycle behind sample_in/gain.
module dk3_audio_out #(
  parameter int unsigned MUTE_CYCLES = 2097151,
  parameter int unsigned RAMP_DIV    = 256,
  parameter int unsigned CNT_W       = 21
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               mute_req,
  input  logic [1:0]         vol,
  input  logic signed [15:0] sample_in,
  output logic signed [15:0] audio_l,
  output logic signed [15:0] audio_r,
  output logic [8:0]         gain,
  output logic               muted
);

  localparam int unsigned      DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUTE_CYCLES);
  localparam logic [8:0]       GAIN_MAX = 9'd256;

  typedef enum logic [1:0] {
    S_MUTE,
    S_RAMP,
    S_RUN,
    S_FALL
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [8:0]         gain_q, gain_d;
  logic signed [15:0] audio_q;
  logic               muted_q;

  logic               div_hit;
  logic signed [24:0] prod;
  logic signed [15:0] scaled;
  logic signed [15:0] atten;

  assign div_hit = (div_q == DIV_LAST);

  // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    gain_d  = gain_q;

    case (state_q)
      S_MUTE: begin
        gain_d = '0;
        if (mute_req) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_RAMP;
          div_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RAMP: begin
        if (mute_req) begin
          state_d = S_FALL;
          div_d   = '0;
        end else if (div_hit) begin
          div_d  = '0;
          gain_d = gain_q + 1'b1;
          if (gain_q == GAIN_MAX - 1'b1) begin
            state_d = S_RUN;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_RUN: begin
        gain_d = GAIN_MAX;
        if (mute_req) begin
          state_d = S_FALL;
          div_d   = '0;
        end
      end

      S_FALL: begin
        // A fall requested at gain 0 (mute on the first RAMP cycle) must not wrap below zero.
        if (gain_q == '0) begin
          state_d = S_MUTE;
          cnt_d   = CNT_LOAD;
        end else if (div_hit) begin
          div_d  = '0;
          gain_d = gain_q - 1'b1;
          if (gain_q == 9'd1) begin
            state_d = S_MUTE;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = S_MUTE;
        cnt_d   = CNT_LOAD;
        div_d   = '0;
        gain_d  = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_MUTE;
      cnt_q   <= CNT_LOAD;
      div_q   <= '0;
      gain_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      gain_q  <= gain_d;
    end
  end

  // Gain is at most 256, so after the >>> 8 the magnitude never exceeds the input's and 16 bits suffice.
  assign prod   = sample_in * $signed({1'b0, gain_q});
  assign scaled = 16'(prod >>> 8);
  assign atten  = scaled >>> vol;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      audio_q <= '0;
      muted_q <= 1'b1;
    end else begin
      audio_q <= atten;
      muted_q <= (gain_q == '0);
    end
  end

  assign audio_l = audio_q;
  assign audio_r = audio_q;
  assign gain    = gain_q;
  assign muted   = muted_q;

endmodule

// File: tb/tb_dk3_audio_out.sv
// Scoreboard bench for dk3_audio_out with short mute and ramp timings.
// Expected values are queued with a cycle stamp; a negedge monitor pops and compares them.
module tb_dk3_audio_out;

  localparam int MC = 16;
  localparam int RD = 4;
  localparam int T0 = 4;

  logic               clk_sys = 1'b0;
  logic               reset = 1'b1;
  logic               mute_req = 1'b0;
  logic [1:0]         vol = 2'd0;
  logic signed [15:0] sample_in = 16'sh4000;
  logic signed [15:0] audio_l;
  logic signed [15:0] audio_r;
  logic [8:0]         gain;
  logic               muted;

  dk3_audio_out #(
    .MUTE_CYCLES(MC),
    .RAMP_DIV   (RD),
    .CNT_W      (5)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .mute_req (mute_req),
    .vol      (vol),
    .sample_in(sample_in),
    .audio_l  (audio_l),
    .audio_r  (audio_r),
    .gain     (gain),
    .muted    (muted)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef enum {K_GAIN, K_AUDIO, K_MUTED} kind_e;
  typedef struct {
    int    at;
    kind_e kind;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // k is counted in clock edges after the first reset edge seen at cycle T0.
  task automatic expect_at(input int k, input kind_e kind, input int exp, input string name);
    exp_t e;
    e.at = T0 + k;
    e.kind = kind;
    e.exp = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int k);
    while (cyc < T0 + k) @(negedge clk_sys);
  endtask

  always @(negedge clk_sys) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) begin
        check({e.name, "_missed"}, cyc, e.at);
      end else begin
        case (e.kind)
          K_GAIN:  check(e.name, int'(gain), e.exp);
          K_MUTED: check(e.name, int'(muted), e.exp);
          default: begin
            check(e.name, int'(audio_l), e.exp);
            check({e.name, "_r"}, int'(audio_r), e.exp);
          end
        endcase
      end
    end
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up: 17 MUTE cycles, ramp steps every 4 cycles, output lags gain by one cycle.
    expect_at(0,    K_GAIN,  0,     "rst_gain");
    expect_at(0,    K_AUDIO, 0,     "rst_audio");
    expect_at(0,    K_MUTED, 1,     "rst_muted");
    expect_at(1,    K_AUDIO, 0,     "pu1_audio");
    expect_at(17,   K_MUTED, 1,     "pu17_muted");
    expect_at(17,   K_AUDIO, 0,     "pu17_audio");
    expect_at(20,   K_GAIN,  0,     "pu20_gain");
    expect_at(21,   K_GAIN,  1,     "pu_first_step");
    expect_at(21,   K_MUTED, 1,     "pu21_muted");
    expect_at(22,   K_AUDIO, 64,    "pu22_audio");
    expect_at(22,   K_MUTED, 0,     "pu22_muted");
    expect_at(25,   K_GAIN,  2,     "pu_second_step");
    expect_at(26,   K_AUDIO, 128,   "pu26_audio");
    expect_at(417,  K_GAIN,  100,   "pu_gain100");
    expect_at(1040, K_GAIN,  255,   "pu_gain255");
    expect_at(1041, K_GAIN,  256,   "pu_gain256");
    expect_at(1041, K_AUDIO, 16320, "pu1041_audio");
    expect_at(1042, K_AUDIO, 16384, "run_audio");
    expect_at(1100, K_GAIN,  256,   "run_hold");
    wait_to(0);
    reset = 1'b0;

    // Attenuation and floor rounding in RUN.
    wait_to(1100);
    expect_at(1101, K_AUDIO, -1000, "vol0");
    expect_at(1102, K_AUDIO, -500,  "vol1");
    expect_at(1103, K_AUDIO, -250,  "vol2");
    expect_at(1104, K_AUDIO, -125,  "vol3");
    expect_at(1105, K_AUDIO, -1,    "floor_m1_vol3");
    expect_at(1106, K_AUDIO, -501,  "floor_m1001_vol1");
    expect_at(1107, K_AUDIO, 16384, "run_restore");
    sample_in = -16'sd1000;
    vol = 2'd0;
    wait_to(1101); vol = 2'd1;
    wait_to(1102); vol = 2'd2;
    wait_to(1103); vol = 2'd3;
    wait_to(1104); sample_in = -16'sd1;
    wait_to(1105); sample_in = -16'sd1001; vol = 2'd1;
    wait_to(1106); sample_in = 16'sh4000; vol = 2'd0;

    // One-cycle mute pulse: full fall, 17 MUTE cycles, ramp again.
    wait_to(1110);
    expect_at(1111, K_GAIN,  256,   "pulse_gain_kept");
    expect_at(1114, K_GAIN,  256,   "fall_before_step");
    expect_at(1115, K_GAIN,  255,   "fall_first_step");
    expect_at(1116, K_AUDIO, 16320, "fall_audio255");
    expect_at(1335, K_GAIN,  200,   "fall_gain200");
    expect_at(1336, K_AUDIO, 12800, "fall_audio200");
    expect_at(2134, K_GAIN,  1,     "fall_gain1");
    expect_at(2135, K_GAIN,  0,     "fall_gain0");
    expect_at(2135, K_AUDIO, 64,    "fall_last_audio");
    expect_at(2135, K_MUTED, 0,     "fall_last_muted");
    expect_at(2136, K_AUDIO, 0,     "mute_audio");
    expect_at(2136, K_MUTED, 1,     "mute_muted");
    expect_at(2155, K_GAIN,  0,     "remute_gain0");
    expect_at(2156, K_GAIN,  1,     "reramp_step");
    expect_at(2157, K_AUDIO, 64,    "reramp_audio");
    mute_req = 1'b1;
    wait_to(1111);
    mute_req = 1'b0;

    // Mute raised in RAMP at gain 100 on a step cycle, then held in MUTE.
    wait_to(2550);
    expect_at(2555, K_GAIN,  100, "ramp_gain100");
    expect_at(2556, K_GAIN,  100, "mute_over_step");
    expect_at(2559, K_GAIN,  100, "fall100_hold");
    expect_at(2560, K_GAIN,  99,  "fall100_step");
    expect_at(2955, K_GAIN,  1,   "fall100_gain1");
    expect_at(2956, K_GAIN,  0,   "fall100_done");
    expect_at(2957, K_MUTED, 1,   "held_muted");
    expect_at(2957, K_AUDIO, 0,   "held_audio");
    expect_at(3050, K_GAIN,  0,   "held_gain_a");
    expect_at(3100, K_GAIN,  0,   "held_gain_b");
    expect_at(3100, K_MUTED, 1,   "held_muted_b");
    expect_at(3120, K_GAIN,  0,   "release_pre_step");
    expect_at(3121, K_GAIN,  1,   "release_first_step");
    wait_to(2555);
    mute_req = 1'b1;
    wait_to(3100);
    mute_req = 1'b0;

    // Reset mid-RAMP at gain 57.
    wait_to(3300);
    expect_at(3345, K_GAIN,  57,   "ramp_gain57");
    expect_at(3345, K_AUDIO, 3584, "ramp_audio56");
    expect_at(3346, K_GAIN,  0,    "midrst_gain");
    expect_at(3346, K_AUDIO, 0,    "midrst_audio");
    expect_at(3346, K_MUTED, 1,    "midrst_muted");
    expect_at(3366, K_GAIN,  0,    "midrst_full_cnt");
    expect_at(3367, K_GAIN,  1,    "midrst_first_step");
    expect_at(3368, K_AUDIO, 64,   "midrst_audio64");
    wait_to(3345);
    reset = 1'b1;
    wait_to(3346);
    reset = 1'b0;

    wait_to(3370);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_sys);
    while (sb.size() > 0) begin
      n_checks++;
      $display("FAIL %s: not checked, still pending at cycle %0d", sb[0].name, cyc);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
